stream_decoder: RTL and testbench



---
 rtl/stream_decoder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_stream_decoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_decoder.sv
// stream_decoder
//   Receive-side decoder for the fast-bus shared-data link. It parses the
//   decoded RX byte stream into framed 32-bit words. Each word is written into
//   one of N_OUT shared-memory segments as a single-beat AXI4-Lite write.
//
//   Frame format:
//     K 0x5C | header{dest[3:0], cnt[3:0]} | 4*cnt data bytes | K 0x3C | tag hi | tag lo
//
// Ports
//   clk, rst_n              single clock; asynchronous active-low reset
//   rx_data_in, rx_isk_in   one decoded byte per clock, plus its K flag
//   sd_*                    write-only AXI4-Lite masters, one lane per segment.
//                           The packed [N_OUT-1:0] dimension selects the port.
//                           The read channel is tied off.
//   frame_err               one-cycle pulse on any framing error
//   last_tag                trailer of the last completed frame
module stream_decoder #(
   parameter int AW     = 11,
   parameter int DW     = 32,
   parameter int N_OUT  = 2,
   parameter int FIFO_D = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [7:0]                   rx_data_in,
   input  logic                         rx_isk_in,
   output logic [N_OUT-1:0]             sd_awvalid_o,
   input  logic [N_OUT-1:0]             sd_awready_i,
   output logic [N_OUT-1:0][AW-1:0]     sd_awaddr_o,
   output logic [N_OUT-1:0][2:0]        sd_awprot_o,
   output logic [N_OUT-1:0]             sd_wvalid_o,
   input  logic [N_OUT-1:0]             sd_wready_i,
   output logic [N_OUT-1:0][DW-1:0]     sd_wdata_o,
   output logic [N_OUT-1:0][DW/8-1:0]   sd_wstrb_o,
   input  logic [N_OUT-1:0]             sd_bvalid_i,
   output logic [N_OUT-1:0]             sd_bready_o,
   output logic [N_OUT-1:0]             sd_arvalid_o,
   output logic [N_OUT-1:0][AW-1:0]     sd_araddr_o,
   output logic [N_OUT-1:0]             sd_rready_o,
   output logic                         frame_err,
   output logic [15:0]                  last_tag
);

   localparam logic [7:0] K_SOF = 8'h5C;
   localparam logic [7:0] K_EOF = 8'h3C;
   localparam int         PW    = $clog2(FIFO_D);

   typedef enum logic [2:0] {P_IDLE, P_HDR, P_DATA, P_WAIT_EOF, P_TAG0, P_TAG1} p_state_e;
   typedef enum logic [1:0] {E_IDLE, E_WR, E_B} e_state_e;

   typedef struct packed {
      logic [3:0]  dest;
      logic [3:0]  idx;
      logic [31:0] data;
   } entry_t;

   // ---------------- parser ----------------
   p_state_e    p_state_q;
   logic [3:0]  dest_q, cnt_q, word_idx_q;
   logic        dest_ok_q;
   logic [1:0]  byte_idx_q;
   logic [23:0] shift_q;
   logic [7:0]  tag0_q;
   logic [15:0] last_tag_q;
   logic        frame_err_q;

   logic is_sof, is_eof, is_data;
   assign is_sof  = rx_isk_in && (rx_data_in == K_SOF);
   assign is_eof  = rx_isk_in && (rx_data_in == K_EOF);
   assign is_data = !rx_isk_in;

   // ---------------- word FIFO ----------------
   entry_t        mem_q [FIFO_D];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;
   logic          fifo_full, fifo_empty, push, pop;
   entry_t        push_entry, head;

   assign fifo_full  = (count_q == (PW+1)'(FIFO_D));
   assign fifo_empty = (count_q == '0);
   // Words for an out-of-range destination are counted but never queued.
   assign push = (p_state_q == P_DATA) && is_data && (byte_idx_q == 2'd3)
                 && dest_ok_q && !fifo_full;
   assign push_entry = '{dest: dest_q, idx: word_idx_q, data: {shift_q, rx_data_in}};
   assign head       = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_state_q   <= P_IDLE;
         dest_q      <= '0;
         cnt_q       <= '0;
         word_idx_q  <= '0;
         dest_ok_q   <= 1'b0;
         byte_idx_q  <= '0;
         shift_q     <= '0;
         tag0_q      <= '0;
         last_tag_q  <= '0;
         frame_err_q <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments only, so every
         // branch below sees the register values from before this edge.
         frame_err_q <= 1'b0;
         unique case (p_state_q)
            P_IDLE: if (is_sof) p_state_q <= P_HDR;
            P_HDR: begin
               if (is_sof) begin
                  frame_err_q <= 1'b1;
               end else if (is_data) begin
                  dest_q     <= rx_data_in[7:4];
                  cnt_q      <= rx_data_in[3:0];
                  dest_ok_q  <= ({28'd0, rx_data_in[7:4]} < N_OUT);
                  word_idx_q <= '0;
                  byte_idx_q <= '0;
                  if ({28'd0, rx_data_in[7:4]} >= N_OUT) frame_err_q <= 1'b1;
                  p_state_q  <= (rx_data_in[3:0] == 4'd0) ? P_WAIT_EOF : P_DATA;
               end
            end
            P_DATA: begin
               if (is_sof) begin
                  frame_err_q <= 1'b1;
                  p_state_q   <= P_HDR;
               end else if (is_eof) begin
                  // Early EOF: the partial word is dropped and queued words stay queued.
                  frame_err_q <= 1'b1;
                  p_state_q   <= P_IDLE;
               end else if (is_data) begin
                  shift_q    <= {shift_q[15:0], rx_data_in};
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     if (dest_ok_q && fifo_full) frame_err_q <= 1'b1;
                     word_idx_q <= word_idx_q + 4'd1;
                     if (word_idx_q == cnt_q - 4'd1) p_state_q <= P_WAIT_EOF;
                  end
               end
            end
            P_WAIT_EOF: begin
               if (is_sof) begin
                  frame_err_q <= 1'b1;
                  p_state_q   <= P_HDR;
               end else if (is_eof) begin
                  p_state_q <= P_TAG0;
               end else if (is_data) begin
                  frame_err_q <= 1'b1;
                  p_state_q   <= P_IDLE;
               end
            end
            // The tag bytes must be data. SOF restarts the parser; any other
            // K character aborts the frame and leaves last_tag untouched.
            P_TAG0: begin
               if (is_sof) begin
                  frame_err_q <= 1'b1;
                  p_state_q   <= P_HDR;
               end else if (rx_isk_in) begin
                  frame_err_q <= 1'b1;
                  p_state_q   <= P_IDLE;
               end else begin
                  tag0_q    <= rx_data_in;
                  p_state_q <= P_TAG1;
               end
            end
            P_TAG1: begin
               if (is_sof) begin
                  frame_err_q <= 1'b1;
                  p_state_q   <= P_HDR;
               end else if (rx_isk_in) begin
                  frame_err_q <= 1'b1;
                  p_state_q   <= P_IDLE;
               end else begin
                  last_tag_q <= {tag0_q, rx_data_in};
                  p_state_q  <= P_IDLE;
               end
            end
            default: p_state_q <= P_IDLE;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset. Only the pointers and
   // the count must come up known, because they define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------- AXI write engine ----------------
   e_state_e         e_state_q;
   logic [AW-1:0]    awaddr_q;
   logic [DW-1:0]    wdata_q;
   logic [N_OUT-1:0] awvalid_q, wvalid_q, bready_q, sel_oh_q;
   logic [N_OUT-1:0] head_oh;
   logic             aw_left, w_left;

   assign pop     = (e_state_q == E_IDLE) && !fifo_empty;
   assign head_oh = N_OUT'(1) << head.dest;
   // A channel is still pending if its valid stays up without a ready this cycle.
   assign aw_left = |(awvalid_q & ~sd_awready_i);
   assign w_left  = |(wvalid_q  & ~sd_wready_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_state_q <= E_IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         awvalid_q <= '0;
         wvalid_q  <= '0;
         bready_q  <= '0;
         sel_oh_q  <= '0;
      end else begin
         unique case (e_state_q)
            E_IDLE: if (pop) begin
               awaddr_q  <= AW'({head.idx, 2'b00});
               wdata_q   <= head.data;
               sel_oh_q  <= head_oh;
               awvalid_q <= head_oh;
               wvalid_q  <= head_oh;
               e_state_q <= E_WR;
            end
            E_WR: begin
               awvalid_q <= awvalid_q & ~sd_awready_i;
               wvalid_q  <= wvalid_q  & ~sd_wready_i;
               if (!aw_left && !w_left) begin
                  bready_q  <= sel_oh_q;
                  e_state_q <= E_B;
               end
            end
            E_B: if (|(bready_q & sd_bvalid_i)) begin
               bready_q  <= '0;
               e_state_q <= E_IDLE;
            end
            default: e_state_q <= E_IDLE;
         endcase
      end
   end

   // Address and data are broadcast to every port; only the selected port sees valid.
   assign sd_awvalid_o = awvalid_q;
   assign sd_wvalid_o  = wvalid_q;
   assign sd_bready_o  = bready_q;
   assign sd_awaddr_o  = {N_OUT{awaddr_q}};
   assign sd_wdata_o   = {N_OUT{wdata_q}};
   assign sd_wstrb_o   = {N_OUT{{(DW/8){1'b1}}}};
   assign sd_awprot_o  = '0;
   assign sd_arvalid_o = '0;
   assign sd_araddr_o  = '0;
   assign sd_rready_o  = '0;
   assign frame_err    = frame_err_q;
   assign last_tag     = last_tag_q;

endmodule

// File: tb/tb_stream_decoder.sv
// Testbench for stream_decoder.
// Stimulus is driven as whole frames. Expected writes are derived from the
// frame contents: payload word k of a frame for a valid destination becomes a
// write of that word to address 4*k. They are queued per port, and a
// responding AXI slave model on each port pops and compares every write it
// receives.
module tb_stream_decoder;
   localparam int AW = 11, DW = 32, N_OUT = 2, FIFO_D = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] rx_data = 8'hBC;
   logic       rx_isk  = 1'b1;

   logic [N_OUT-1:0]           awvalid, wvalid, bready, arvalid, rready;
   logic [N_OUT-1:0]           awready = '0, wready = '0, bvalid = '0;
   logic [N_OUT-1:0][AW-1:0]   awaddr, araddr;
   logic [N_OUT-1:0][2:0]      awprot;
   logic [N_OUT-1:0][DW-1:0]   wdata;
   logic [N_OUT-1:0][DW/8-1:0] wstrb;
   logic                       frame_err;
   logic [15:0]                last_tag;

   stream_decoder #(.AW(AW), .DW(DW), .N_OUT(N_OUT), .FIFO_D(FIFO_D)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data_in(rx_data), .rx_isk_in(rx_isk),
      .sd_awvalid_o(awvalid), .sd_awready_i(awready), .sd_awaddr_o(awaddr),
      .sd_awprot_o(awprot), .sd_wvalid_o(wvalid), .sd_wready_i(wready),
      .sd_wdata_o(wdata), .sd_wstrb_o(wstrb), .sd_bvalid_i(bvalid),
      .sd_bready_o(bready), .sd_arvalid_o(arvalid), .sd_araddr_o(araddr),
      .sd_rready_o(rready), .frame_err(frame_err), .last_tag(last_tag)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int err_cnt = 0, exp_err = 0;
   logic [15:0] exp_tag = 16'h0000;
   logic [63:0] exp_q0[$], exp_q1[$];
   int aw_dly = 0, w_dly = 0, b_dly = 0;
   logic [31:0] pay [16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_push(input int p, input logic [31:0] addr, input logic [31:0] data);
      if (p == 0) exp_q0.push_back({addr, data});
      else        exp_q1.push_back({addr, data});
   endtask

   // Count frame_err pulses while the design is out of reset.
   always @(negedge clk) if (rst_n && frame_err) err_cnt++;

   // ---------------- AXI slave model with scoreboard ----------------
   int          aw_wait[N_OUT], w_wait[N_OUT], b_wait[N_OUT];
   bit          aw_hs[N_OUT], w_hs[N_OUT], b_hs[N_OUT];
   bit          aw_got[N_OUT], w_got[N_OUT], aw_seen[N_OUT], w_seen[N_OUT], cmp_done[N_OUT];
   logic [AW-1:0] first_addr[N_OUT], cap_addr[N_OUT];
   logic [31:0]   first_data[N_OUT], cap_data[N_OUT];

   task automatic slave_clear();
      awready = '0; wready = '0; bvalid = '0;
      for (int p = 0; p < N_OUT; p++) begin
         aw_wait[p] = 0; w_wait[p] = 0; b_wait[p] = 0;
         aw_hs[p] = 0; w_hs[p] = 0; b_hs[p] = 0;
         aw_got[p] = 0; w_got[p] = 0; aw_seen[p] = 0; w_seen[p] = 0; cmp_done[p] = 0;
      end
   endtask

   task automatic score(input int p);
      logic [63:0] e;
      check($sformatf("p%0d_awaddr_stable", p), 64'(cap_addr[p]), 64'(first_addr[p]));
      check($sformatf("p%0d_wdata_stable", p), 64'(cap_data[p]), 64'(first_data[p]));
      check($sformatf("p%0d_wstrb", p), 64'(wstrb[p]), 64'hF);
      if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL p%0d_unexpected_write: got addr 0x%0h data 0x%0h, required none",
                  p, cap_addr[p], cap_data[p]);
      end else begin
         e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         check($sformatf("p%0d_write", p), {32'(cap_addr[p]), cap_data[p]}, e);
      end
   endtask

   initial begin
      slave_clear();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            slave_clear();
            continue;
         end
         for (int p = 0; p < N_OUT; p++) begin
            if (aw_hs[p]) begin
               awready[p] = 1'b0; aw_hs[p] = 0; aw_got[p] = 1;
            end else if (!aw_got[p] && awvalid[p]) begin
               if (!aw_seen[p]) begin aw_seen[p] = 1; first_addr[p] = awaddr[p]; end
               if (aw_wait[p] >= aw_dly) begin
                  awready[p] = 1'b1; aw_hs[p] = 1; cap_addr[p] = awaddr[p];
               end else aw_wait[p]++;
            end
            if (w_hs[p]) begin
               wready[p] = 1'b0; w_hs[p] = 0; w_got[p] = 1;
            end else if (!w_got[p] && wvalid[p]) begin
               if (!w_seen[p]) begin w_seen[p] = 1; first_data[p] = wdata[p]; end
               if (w_wait[p] >= w_dly) begin
                  wready[p] = 1'b1; w_hs[p] = 1; cap_data[p] = wdata[p];
               end else w_wait[p]++;
            end
            if (aw_got[p] && w_got[p] && !cmp_done[p]) begin
               cmp_done[p] = 1;
               score(p);
            end
            if (b_hs[p]) begin
               bvalid[p] = 1'b0; b_hs[p] = 0;
               aw_got[p] = 0; w_got[p] = 0; aw_seen[p] = 0; w_seen[p] = 0; cmp_done[p] = 0;
               aw_wait[p] = 0; w_wait[p] = 0; b_wait[p] = 0;
            end else begin
               if (!bvalid[p] && aw_got[p] && w_got[p]) begin
                  if (b_wait[p] >= b_dly) bvalid[p] = 1'b1; else b_wait[p]++;
               end
               if (bvalid[p] && bready[p]) b_hs[p] = 1;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic k, input logic [7:0] d);
      @(negedge clk);
      rx_isk  = k;
      rx_data = d;
   endtask

   task automatic maybe_fill(input bit fill);
      if (fill && $urandom_range(0, 3) == 0) send(1'b1, 8'hBC);
   endtask

   // Sends a well-formed frame from pay[] and records what it must produce.
   task automatic send_frame(input logic [7:0] hdr, input logic [15:0] tag, input bit fill);
      int dest = int'(hdr[7:4]);
      int cnt  = int'(hdr[3:0]);
      send(1'b1, 8'h5C);
      maybe_fill(fill);
      send(1'b0, hdr);
      if (dest >= N_OUT) exp_err++;
      for (int k = 0; k < cnt; k++) begin
         for (int b = 0; b < 4; b++) begin
            maybe_fill(fill);
            send(1'b0, pay[k][31-8*b -: 8]);
         end
         if (dest < N_OUT) exp_push(dest, 32'(4*k), pay[k]);
      end
      maybe_fill(fill);
      send(1'b1, 8'h3C);
      send(1'b0, tag[15:8]);
      send(1'b0, tag[7:0]);
      exp_tag = tag;
      send(1'b1, 8'hBC);
   endtask

   function automatic bit slave_busy();
      bit b = (awvalid != '0) || (wvalid != '0) || (bready != '0) || (bvalid != '0);
      for (int p = 0; p < N_OUT; p++) b = b || aw_got[p] || w_got[p];
      return b;
   endfunction

   task automatic drain_and_check(input string name);
      int t = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0 || slave_busy()) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      check({name, "_drain_timeout"}, 64'(t >= 3000), 64'd0);
      check({name, "_frame_err_count"}, 64'(err_cnt), 64'(exp_err));
      check({name, "_last_tag"}, 64'(last_tag), 64'(exp_tag));
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_awvalid"}, 64'(awvalid), 64'd0);
      check({name, "_wvalid"}, 64'(wvalid), 64'd0);
      check({name, "_bready"}, 64'(bready), 64'd0);
      check({name, "_awaddr"}, 64'(awaddr), 64'd0);
      check({name, "_wdata"}, 64'(wdata), 64'd0);
      check({name, "_frame_err"}, 64'(frame_err), 64'd0);
      check({name, "_last_tag"}, 64'(last_tag), 64'd0);
      check({name, "_read_tieoff"}, {arvalid, rready, 2'b00, araddr[1], araddr[0], awprot}, 64'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Reference frame, fast slave.
      pay[0] = 32'hAD74AD74; pay[1] = 32'h7A3474AD; pay[2] = 32'hAD74AD74; pay[3] = 32'h7A3474AD;
      send_frame(8'h04, 16'hFADF, 1'b0);
      drain_and_check("ref_fast");

      // Same frame, slow slave.
      aw_dly = 5; w_dly = 1; b_dly = 3;
      send_frame(8'h04, 16'hFADF, 1'b0);
      drain_and_check("ref_slow");
      aw_dly = 0; w_dly = 0; b_dly = 0;

      // Destination 1, three words.
      pay[0] = 32'h01020304; pay[1] = 32'hCAFEF00D; pay[2] = 32'h55AA33CC;
      send_frame(8'h13, 16'h1357, 1'b0);
      drain_and_check("dest1");

      // Empty payload.
      send_frame(8'h00, 16'hBEEF, 1'b0);
      drain_and_check("cnt0");

      // Two words announced, EOF after five bytes: only word 0 survives.
      send(1'b1, 8'h5C); send(1'b0, 8'h02);
      send(1'b0, 8'hAA); send(1'b0, 8'hBB); send(1'b0, 8'hCC); send(1'b0, 8'hDD);
      exp_push(0, 32'h0, 32'hAABBCCDD);
      send(1'b0, 8'hEE); send(1'b1, 8'h3C); send(1'b1, 8'hBC);
      exp_err++;
      drain_and_check("early_eof");

      // SOF inside a payload restarts on the new frame.
      send(1'b1, 8'h5C); send(1'b0, 8'h01); send(1'b0, 8'hAA); send(1'b0, 8'hBB);
      exp_err++;
      pay[0] = 32'h11223344;
      send_frame(8'h01, 16'h1234, 1'b0);
      drain_and_check("sof_restart");

      // Destination out of range: consumed, no writes.
      pay[0] = 32'hDEADBEEF;
      send_frame(8'hF1, 16'h4321, 1'b0);
      drain_and_check("bad_dest");

      // Idle fill mid-frame, then reset before any word completes.
      send(1'b1, 8'h5C); send(1'b0, 8'h12); send(1'b1, 8'hBC);
      send(1'b0, 8'hAA); send(1'b1, 8'hBC); send(1'b0, 8'hBB);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("midframe_reset");
      exp_tag = 16'h0000;
      rst_n = 1'b1;
      pay[0] = 32'h0BADC0DE; pay[1] = 32'h76543210;
      send_frame(8'h12, 16'h9ABC, 1'b1);
      drain_and_check("after_reset");

      // Randomized frames with idle fill and varying slave latency.
      for (int f = 0; f < 40; f++) begin
         logic [3:0] d, c;
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
         d = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
         c = 4'($urandom_range(0, 15));
         for (int k = 0; k < 16; k++) pay[k] = $urandom;
         send_frame({d, c}, 16'($urandom), 1'b1);
         drain_and_check($sformatf("rand%0d", f));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
